poker_player_ctrl: RTL and testbench

POKER_PLAYER_CTRL -- requirements
Module: poker_player_ctrl

---
 rtl/poker_player_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_poker_player_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/poker_player_ctrl.sv
// Poker seat controller: takes dealer commands addressed to this seat, keeps the
// hand and chip balance, and walks deal/sort/bet/swap/bet/result with one response per command.
module poker_player_ctrl #(
   parameter int PLAYER_ID  = 6,
   parameter int PID_W      = 3,
   parameter int HAND_SIZE  = 5,
   parameter int MAX_SWAP   = 4,
   parameter int CHIP_W     = 8,
   parameter int INIT_CHIPS = 100,
   parameter int RAISE_STEP = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         dlr_valid,
   input  logic [PID_W-1:0]             dlr_pid,
   input  logic [2:0]                   dlr_cmd,
   input  logic [7:0]                   dlr_data,
   input  logic                         sort_done,
   input  logic [$clog2(MAX_SWAP+1)-1:0] swap_cnt,
   input  logic [3*MAX_SWAP-1:0]        swap_idx,
   input  logic                         raise,
   input  logic                         weak_hand,
   input  logic                         win,
   input  logic [CHIP_W-1:0]            pot,
   output logic                         rsp_valid,
   output logic                         rsp_err,
   output logic [CHIP_W-1:0]            rsp_data,
   output logic                         fold,
   output logic                         start_sort,
   output logic [8*HAND_SIZE-1:0]       hand_flat,
   output logic [CHIP_W-1:0]            chips,
   output logic [3:0]                   state_o
);

   localparam int SC_W = $clog2(MAX_SWAP+1);
   localparam int DC_W = $clog2(HAND_SIZE+1);
   localparam int CW1  = CHIP_W + 1;

   localparam logic [2:0] CMD_DEAL     = 3'd0;
   localparam logic [2:0] CMD_BET      = 3'd1;
   localparam logic [2:0] CMD_SWAP_OUT = 3'd2;
   localparam logic [2:0] CMD_SWAP_IN  = 3'd3;
   localparam logic [2:0] CMD_RESULT   = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_DEAL     = 4'd1,
      S_SORT     = 4'd2,
      S_BET1     = 4'd3,
      S_SWAP_OUT = 4'd4,
      S_SWAP_IN  = 4'd5,
      S_BET2     = 4'd6,
      S_WAIT_RES = 4'd7,
      S_OUT      = 4'd8
   } state_t;

   state_t                state;
   logic [7:0]            hand [HAND_SIZE];
   logic [DC_W-1:0]       deal_cnt;
   logic [SC_W-1:0]       swap_ptr;
   logic [SC_W-1:0]       swap_cnt_r;
   logic [3*MAX_SWAP-1:0] swap_idx_r;

   logic                  accept;
   logic [2:0]            sel_raw;
   logic [2:0]            sel_idx;
   logic [7:0]            sel_card;
   logic [CW1-1:0]        amt;
   logic [CW1-1:0]        amt_raise;
   logic [CW1-1:0]        chips_x;
   logic [CHIP_W-1:0]     res_chips;

   function automatic logic [CHIP_W-1:0] sat_add(input logic [CHIP_W-1:0] a,
                                                 input logic [CHIP_W-1:0] b);
      logic [CHIP_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[CHIP_W] ? {CHIP_W{1'b1}} : s[CHIP_W-1:0];
   endfunction

   assign accept    = dlr_valid && (dlr_pid == PID_W'(PLAYER_ID));
   assign amt       = CW1'(dlr_data);
   assign amt_raise = amt + CW1'(RAISE_STEP);
   assign chips_x   = {1'b0, chips};
   assign res_chips = (win && !fold) ? sat_add(chips, pot) : chips;
   assign state_o   = state;

   // Current swap slot; out-of-range hand indices fall back to card 0
   always_comb begin
      sel_raw = '0;
      for (int i = 0; i < MAX_SWAP; i++)
         if (swap_ptr == SC_W'(i)) sel_raw = swap_idx_r[3*i +: 3];
      sel_idx = ({1'b0, sel_raw} < 4'(HAND_SIZE)) ? sel_raw : 3'd0;
      sel_card = '0;
      for (int i = 0; i < HAND_SIZE; i++)
         if (sel_idx == 3'(i)) sel_card = hand[i];
   end

   always_comb begin
      hand_flat = '0;
      for (int i = 0; i < HAND_SIZE; i++) hand_flat[8*i +: 8] = hand[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         chips      <= CHIP_W'(INIT_CHIPS);
         for (int i = 0; i < HAND_SIZE; i++) hand[i] <= '0;
         deal_cnt   <= '0;
         swap_ptr   <= '0;
         swap_cnt_r <= '0;
         swap_idx_r <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_data   <= '0;
         fold       <= 1'b0;
         start_sort <= 1'b0;
      end else begin
         rsp_valid  <= accept;
         rsp_err    <= 1'b0;
         start_sort <= 1'b0;

         if (state == S_SORT && sort_done) begin
            swap_cnt_r <= (swap_cnt > SC_W'(MAX_SWAP)) ? SC_W'(MAX_SWAP) : swap_cnt;
            swap_idx_r <= swap_idx;
            swap_ptr   <= '0;
            state      <= S_BET1;
         end

         if (accept) begin
            rsp_data <= '0;
            case (state)
               S_IDLE, S_DEAL: begin
                  if (dlr_cmd == CMD_DEAL) begin
                     for (int i = 0; i < HAND_SIZE; i++)
                        if (deal_cnt == DC_W'(i)) hand[i] <= dlr_data;
                     deal_cnt <= deal_cnt + 1'b1;
                     if (deal_cnt == DC_W'(HAND_SIZE-1)) begin
                        state      <= S_SORT;
                        start_sort <= 1'b1;
                     end else begin
                        state <= S_DEAL;
                     end
                  end else rsp_err <= 1'b1;
               end
               S_BET1: begin
                  if (dlr_cmd == CMD_BET) begin
                     if (chips_x < amt) begin
                        fold  <= 1'b1;
                        state <= S_OUT;
                     end else begin
                        chips    <= chips - amt[CHIP_W-1:0];
                        rsp_data <= amt[CHIP_W-1:0];
                        state    <= S_SWAP_OUT;
                     end
                  end else rsp_err <= 1'b1;
               end
               S_SWAP_OUT: begin
                  if (dlr_cmd == CMD_SWAP_OUT) begin
                     if (swap_ptr < swap_cnt_r) begin
                        rsp_data <= CHIP_W'(sel_card);
                        swap_ptr <= swap_ptr + 1'b1;
                     end else begin
                        rsp_data <= '1;
                        swap_ptr <= '0;
                        state    <= (swap_cnt_r == '0) ? S_BET2 : S_SWAP_IN;
                     end
                  end else rsp_err <= 1'b1;
               end
               S_SWAP_IN: begin
                  if (dlr_cmd == CMD_SWAP_IN) begin
                     for (int i = 0; i < HAND_SIZE; i++)
                        if (sel_idx == 3'(i)) hand[i] <= dlr_data;
                     if (swap_ptr + 1'b1 == swap_cnt_r) begin
                        swap_ptr <= '0;
                        state    <= S_BET2;
                     end else begin
                        swap_ptr <= swap_ptr + 1'b1;
                     end
                  end else rsp_err <= 1'b1;
               end
               S_BET2: begin
                  if (dlr_cmd == CMD_BET) begin
                     if (weak_hand || chips_x < amt) begin
                        fold  <= 1'b1;
                        state <= S_OUT;
                     end else if (raise && chips_x >= amt_raise) begin
                        chips    <= chips - amt_raise[CHIP_W-1:0];
                        rsp_data <= amt_raise[CHIP_W-1:0];
                        state    <= S_WAIT_RES;
                     end else begin
                        chips    <= chips - amt[CHIP_W-1:0];
                        rsp_data <= amt[CHIP_W-1:0];
                        state    <= S_WAIT_RES;
                     end
                  end else rsp_err <= 1'b1;
               end
               S_WAIT_RES, S_OUT: begin
                  if (dlr_cmd == CMD_RESULT) begin
                     chips    <= res_chips;
                     rsp_data <= res_chips;
                     fold     <= 1'b0;
                     deal_cnt <= '0;
                     swap_ptr <= '0;
                     state    <= (res_chips == '0) ? S_OUT : S_IDLE;
                  end else rsp_err <= 1'b1;
               end
               default: rsp_err <= 1'b1;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_poker_player_ctrl.sv
// Directed bench for poker_player_ctrl: walks complete hands and checks
// responses, chip balance, hand contents and state against hand-computed values.
module tb_poker_player_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        dlr_valid;
   logic [2:0]  dlr_pid;
   logic [2:0]  dlr_cmd;
   logic [7:0]  dlr_data;
   logic        sort_done;
   logic [2:0]  swap_cnt;
   logic [11:0] swap_idx;
   logic        raise, weak_hand, win;
   logic [7:0]  pot;
   logic        rsp_valid, rsp_err, fold, start_sort;
   logic [7:0]  rsp_data, chips;
   logic [39:0] hand_flat;
   logic [3:0]  state_o;

   int n_pass  = 0;
   int n_total = 0;

   poker_player_ctrl dut (
      .clk(clk), .reset(reset), .dlr_valid(dlr_valid), .dlr_pid(dlr_pid),
      .dlr_cmd(dlr_cmd), .dlr_data(dlr_data), .sort_done(sort_done),
      .swap_cnt(swap_cnt), .swap_idx(swap_idx), .raise(raise),
      .weak_hand(weak_hand), .win(win), .pot(pot), .rsp_valid(rsp_valid),
      .rsp_err(rsp_err), .rsp_data(rsp_data), .fold(fold),
      .start_sort(start_sort), .hand_flat(hand_flat), .chips(chips),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   // One command cycle; returns at the negedge after the accepting posedge
   task automatic send(input logic [2:0] c, input logic [7:0] d, input logic [2:0] p);
      @(negedge clk);
      dlr_valid = 1'b1; dlr_pid = p; dlr_cmd = c; dlr_data = d;
      @(negedge clk);
      dlr_valid = 1'b0;
   endtask

   task automatic do_sort(input logic [2:0] cnt, input logic [11:0] idx);
      @(negedge clk);
      sort_done = 1'b1; swap_cnt = cnt; swap_idx = idx;
      @(negedge clk);
      sort_done = 1'b0;
   endtask

   task automatic deal5(input logic [7:0] base);
      for (int i = 0; i < 5; i++) send(3'd0, base + 8'(i), 3'd6);
   endtask

   task automatic pulse_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_reset();
      pulse_reset();
      n_total++; if (state_o !== 4'd0) $display("FAIL reset_state got %0d want 0", state_o); else n_pass++;
      n_total++; if (chips !== 8'd100) $display("FAIL reset_chips got %0d want 100", chips); else n_pass++;
      n_total++; if (hand_flat !== 40'h0) $display("FAIL reset_hand got %h want 0", hand_flat); else n_pass++;
      n_total++; if ({rsp_valid, rsp_err, fold, start_sort} !== 4'b0)
         $display("FAIL reset_flags got %b want 0000", {rsp_valid, rsp_err, fold, start_sort}); else n_pass++;
   endtask

   task automatic test_deal();
      for (int i = 0; i < 5; i++) begin
         send(3'd0, 8'h11 + 8'(i), 3'd6);
         n_total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0)
            $display("FAIL deal_rsp%0d got v=%b e=%b want v=1 e=0", i, rsp_valid, rsp_err); else n_pass++;
         n_total++; if (start_sort !== (i == 4))
            $display("FAIL deal_start_sort%0d got %b want %b", i, start_sort, (i == 4)); else n_pass++;
      end
      n_total++; if (hand_flat !== 40'h1514131211) $display("FAIL deal_hand got %h want 1514131211", hand_flat); else n_pass++;
      n_total++; if (state_o !== 4'd2) $display("FAIL deal_state got %0d want 2", state_o); else n_pass++;
      @(negedge clk);
      n_total++; if (start_sort !== 1'b0 || rsp_valid !== 1'b0)
         $display("FAIL deal_pulse_width got ss=%b v=%b want 0 0", start_sort, rsp_valid); else n_pass++;
   endtask

   task automatic test_sort();
      send(3'd1, 8'd5, 3'd6);
      n_total++; if (rsp_err !== 1'b1 || state_o !== 4'd2)
         $display("FAIL sort_illegal got err=%b st=%0d want 1 2", rsp_err, state_o); else n_pass++;
      do_sort(3'd2, 12'h00B);
      n_total++; if (state_o !== 4'd3) $display("FAIL sort_to_bet1 got %0d want 3", state_o); else n_pass++;
   endtask

   task automatic test_bet1();
      send(3'd1, 8'd30, 3'd6);
      n_total++; if (rsp_data !== 8'd30 || chips !== 8'd70)
         $display("FAIL bet1 got rsp=%0d chips=%0d want 30 70", rsp_data, chips); else n_pass++;
      n_total++; if (state_o !== 4'd4) $display("FAIL bet1_state got %0d want 4", state_o); else n_pass++;
   endtask

   task automatic test_swap();
      logic [7:0] exp_out [3];
      exp_out[0] = 8'h14; exp_out[1] = 8'h12; exp_out[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         send(3'd2, 8'd0, 3'd6);
         n_total++; if (rsp_data !== exp_out[i] || rsp_err !== 1'b0)
            $display("FAIL swap_out%0d got %h err=%b want %h", i, rsp_data, rsp_err, exp_out[i]); else n_pass++;
      end
      n_total++; if (state_o !== 4'd5) $display("FAIL swap_in_state got %0d want 5", state_o); else n_pass++;
      send(3'd3, 8'h21, 3'd6);
      send(3'd3, 8'h22, 3'd6);
      n_total++; if (hand_flat !== 40'h1521132211) $display("FAIL swap_in_hand got %h want 1521132211", hand_flat); else n_pass++;
      n_total++; if (state_o !== 4'd6) $display("FAIL swap_to_bet2 got %0d want 6", state_o); else n_pass++;
   endtask

   task automatic test_bet2_no_raise_room();
      raise = 1'b1;
      send(3'd1, 8'd60, 3'd6);
      raise = 1'b0;
      n_total++; if (rsp_data !== 8'd60 || chips !== 8'd10 || state_o !== 4'd7)
         $display("FAIL bet2 got rsp=%0d chips=%0d st=%0d want 60 10 7", rsp_data, chips, state_o); else n_pass++;
      win = 1'b0;
      send(3'd4, 8'd0, 3'd6);
      n_total++; if (chips !== 8'd10 || state_o !== 4'd0)
         $display("FAIL result_lose got chips=%0d st=%0d want 10 0", chips, state_o); else n_pass++;
   endtask

   task automatic test_fold();
      deal5(8'h01);
      do_sort(3'd0, 12'h000);
      send(3'd1, 8'd20, 3'd6);
      n_total++; if (fold !== 1'b1 || rsp_data !== 8'd0 || state_o !== 4'd8)
         $display("FAIL fold got f=%b rsp=%0d st=%0d want 1 0 8", fold, rsp_data, state_o); else n_pass++;
      send(3'd1, 8'd1, 3'd6);
      n_total++; if (rsp_err !== 1'b1 || state_o !== 4'd8 || chips !== 8'd10)
         $display("FAIL fold_bet_err got err=%b st=%0d chips=%0d want 1 8 10", rsp_err, state_o, chips); else n_pass++;
      win = 1'b1; pot = 8'd50;
      send(3'd4, 8'd0, 3'd6);
      win = 1'b0;
      n_total++; if (chips !== 8'd10 || state_o !== 4'd0 || fold !== 1'b0)
         $display("FAIL fold_result got chips=%0d st=%0d f=%b want 10 0 0", chips, state_o, fold); else n_pass++;
   endtask

   // Zero-swap hand: BET1 a, SWAP_OUT (all-ones), BET2 b
   task automatic quick_hand(input logic [7:0] a, input logic [7:0] b);
      deal5(8'h40);
      do_sort(3'd0, 12'h000);
      send(3'd1, a, 3'd6);
      send(3'd2, 8'd0, 3'd6);
      n_total++; if (rsp_data !== 8'hFF || state_o !== 4'd6)
         $display("FAIL swap0 got rsp=%h st=%0d want ff 6", rsp_data, state_o); else n_pass++;
      send(3'd1, b, 3'd6);
   endtask

   task automatic test_saturate_raise();
      quick_hand(8'd0, 8'd0);
      win = 1'b1; pot = 8'd240;
      send(3'd4, 8'd0, 3'd6);
      n_total++; if (chips !== 8'd250) $display("FAIL win_add got %0d want 250", chips); else n_pass++;
      quick_hand(8'd0, 8'd0);
      pot = 8'd20;
      send(3'd4, 8'd0, 3'd6);
      win = 1'b0;
      n_total++; if (chips !== 8'd255 || state_o !== 4'd0)
         $display("FAIL saturate got chips=%0d st=%0d want 255 0", chips, state_o); else n_pass++;
      raise = 1'b1;
      quick_hand(8'd5, 8'd10);
      raise = 1'b0;
      n_total++; if (rsp_data !== 8'd26 || chips !== 8'd224)
         $display("FAIL raise got rsp=%0d chips=%0d want 26 224", rsp_data, chips); else n_pass++;
      send(3'd4, 8'd0, 3'd6);
      weak_hand = 1'b1;
      quick_hand(8'd0, 8'd0);
      weak_hand = 1'b0;
      n_total++; if (fold !== 1'b1 || rsp_data !== 8'd0 || state_o !== 4'd8)
         $display("FAIL weak_fold got f=%b rsp=%0d st=%0d want 1 0 8", fold, rsp_data, state_o); else n_pass++;
      send(3'd4, 8'd0, 3'd6);
      n_total++; if (chips !== 8'd224 || state_o !== 4'd0)
         $display("FAIL weak_result got chips=%0d st=%0d want 224 0", chips, state_o); else n_pass++;
   endtask

   task automatic test_broke();
      quick_hand(8'd224, 8'd0);
      n_total++; if (chips !== 8'd0 || state_o !== 4'd7)
         $display("FAIL allin got chips=%0d st=%0d want 0 7", chips, state_o); else n_pass++;
      send(3'd4, 8'd0, 3'd6);
      n_total++; if (state_o !== 4'd8) $display("FAIL broke_park got %0d want 8", state_o); else n_pass++;
      send(3'd0, 8'h77, 3'd6);
      n_total++; if (rsp_err !== 1'b1 || state_o !== 4'd8)
         $display("FAIL broke_deal_err got err=%b st=%0d want 1 8", rsp_err, state_o); else n_pass++;
   endtask

   task automatic test_pid();
      send(3'd4, 8'd0, 3'd5);
      n_total++; if (rsp_valid !== 1'b0 || state_o !== 4'd8)
         $display("FAIL pid_ignored got v=%b st=%0d want 0 8", rsp_valid, state_o); else n_pass++;
      @(negedge clk);
      n_total++; if (rsp_valid !== 1'b0) $display("FAIL pid_quiet got %b want 0", rsp_valid); else n_pass++;
   endtask

   task automatic test_reset_mid();
      pulse_reset();
      deal5(8'h31);
      do_sort(3'd2, 12'h017);
      send(3'd1, 8'd30, 3'd6);
      send(3'd2, 8'd0, 3'd6);
      n_total++; if (rsp_data !== 8'h31) $display("FAIL idx_clamp got %h want 31", rsp_data); else n_pass++;
      send(3'd2, 8'd0, 3'd6);
      n_total++; if (rsp_data !== 8'h33) $display("FAIL idx2 got %h want 33", rsp_data); else n_pass++;
      send(3'd2, 8'd0, 3'd6);
      send(3'd3, 8'h41, 3'd6);
      n_total++; if (hand_flat[7:0] !== 8'h41 || state_o !== 4'd5)
         $display("FAIL mid_swap_in got h0=%h st=%0d want 41 5", hand_flat[7:0], state_o); else n_pass++;
      pulse_reset();
      n_total++; if (state_o !== 4'd0 || chips !== 8'd100 || hand_flat !== 40'h0 || rsp_valid !== 1'b0)
         $display("FAIL mid_reset got st=%0d chips=%0d hand=%h v=%b want 0 100 0 0",
                  state_o, chips, hand_flat, rsp_valid); else n_pass++;
   endtask

   initial begin
      reset = 1'b1; dlr_valid = 1'b0; dlr_pid = '0; dlr_cmd = '0; dlr_data = '0;
      sort_done = 1'b0; swap_cnt = '0; swap_idx = '0;
      raise = 1'b0; weak_hand = 1'b0; win = 1'b0; pot = '0;
      repeat (2) @(negedge clk);
      test_reset();
      test_deal();
      test_sort();
      test_bet1();
      test_swap();
      test_bet2_no_raise_room();
      test_fold();
      test_saturate_raise();
      test_broke();
      test_pid();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
